alu_rsp_deserializer: RTL and testbench
=======================================

# alu_rsp_deserializer

Receive-side front end of the ALU verification environment. Watches the ALU serial output line, deserialises response frames (data or error), checks framing, CRC and parity, and presents one decoded result per response with a single-cycle valid strobe. It sits directly upstream of the scoreboard, which consumes `rsp_valid` in place of a `DONE` event.

## Interface
Parameters:
- `TIMEOUT`, 64: max idle cycles allowed between packets inside one response before abort.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `sout`  in  1  ALU serial output; idle high; one bit per `clk`.
- `rsp_valid`  out  1  one-cycle strobe: new response decoded.
- `rsp_data`  out  32  result C (data responses; 0 for error responses).
- `rsp_flags`  out  4  {carry, overflow, zero, negative} (0 for error responses).
- `rsp_err`  out  6  error flags {ERR_DATA, ERR_CRC, ERR_OP, ERR_DATA, ERR_CRC, ERR_OP} (0 for data responses).
- `rsp_is_err`  out  1  response was an error frame.
- `rsp_chk_ok`  out  1  CRC (data) or parity+duplicate check (error) passed.
- `frame_err`  out  1  one-cycle strobe: malformed or timed-out response discarded.

## Operation
- Packet = 11 bits, MSB first: start `0`, type (`0` data, `1` ctl), 8 payload bits, stop `1`.
- Data response: 4 data packets (C[31:24], C[23:16], C[15:8], C[7:0]) then ctl packet with payload {`0`, FLAGS[3:0], CRC[2:0]}.
- Error response: single ctl packet with payload {`1`, ERR[5:0], PAR}; PAR = even parity such that ^{`1`, ERR, PAR} = 0.
- CRC3: polynomial x^3+x+1, init 0, over 37 bits {C[31:0], `0`, FLAGS[3:0]}, MSB first.
- FSM: IDLE → DATA (byte count 0..3) → CTL → IDLE.
  - IDLE: first ctl packet with payload[7]=1 → decode error frame, strobe `rsp_valid`. Ctl with payload[7]=0 → `frame_err`. Data packet → store byte 0, go DATA.
  - DATA: data packets fill bytes 1..3; after byte 3 go CTL. A ctl packet before byte 3 → `frame_err`, IDLE.
  - CTL: ctl packet with payload[7]=0 → compare CRC, strobe `rsp_valid`, IDLE. Data packet or payload[7]=1 → `frame_err`, IDLE.
- Stop bit sampled `0` in any packet → `frame_err`, FSM to IDLE, receiver waits for line high before hunting next start.
- Timeout: in DATA/CTL, idle counter counts cycles between stop bit and next start; reaching `TIMEOUT` → `frame_err`, IDLE.
- `rsp_chk_ok` for error frames requires parity correct AND ERR[5:3]==ERR[2:0].
- Decoded outputs hold last response until the next `rsp_valid`; never updated on `frame_err`.

## Timing
- Reset (`rst_n`=0 at a clock edge): all outputs 0, FSM IDLE, counters 0, receiver idle. Reset mid-packet discards partial data; no strobe issued.
- `rsp_valid` asserted the cycle after the stop bit of the final packet is sampled (latency 1); `rsp_data`/`rsp_flags`/`rsp_err`/`rsp_is_err`/`rsp_chk_ok` valid in the same cycle.
- `frame_err` asserted the cycle after the offending bit/timeout; never coincident with `rsp_valid`.
- Back-to-back packets (start bit immediately after stop) supported with zero gap.
- Start-of-packet: first `0` sampled while receiver idle; remaining 10 bits sampled on next 10 edges.
- Idle counter saturates; width = $clog2(TIMEOUT+1).

## Structure
- Shared package `alu_pkg`: packet type constants, error flag bit positions, `rsp_state_t` enum, response struct type, `crc3_calc` function (shared with the stimulus generator).
- Sub-module `alu_rsp_byte_rx`: 11-bit shift receiver; outputs `pkt_valid`, `pkt_type`, `pkt_byte[7:0]`, `pkt_stop_err`. Top holds FSM, byte store, CRC/parity checks, timeout.

## Test plan
- Data response C=0x12345678, FLAGS=0000, correct CRC → `rsp_valid` 1 cycle after last stop; `rsp_data`=0x12345678, `rsp_is_err`=0, `rsp_chk_ok`=1.
- Same frame with CRC bit 0 flipped → `rsp_valid`, data 0x12345678, `rsp_chk_ok`=0.
- Error frame ERR=6'b001001 (ERR_OP), correct parity → `rsp_is_err`=1, `rsp_err`=6'b001001, `rsp_data`=0, `rsp_chk_ok`=1; ERR=6'b001010 → `rsp_chk_ok`=0.
- Stop bit `0` in byte 2 → single `frame_err`, no `rsp_valid`; following valid response decoded correctly.
- Gap of `TIMEOUT` cycles after byte 1 → `frame_err`, FSM IDLE; late bytes not merged.
- `rst_n` low during ctl packet → outputs 0, no strobe; back-to-back responses afterwards each yield exactly one `rsp_valid`.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared packet constants, FSM state, response type and CRC3.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int   PKT_BITS      = 11;
    localparam logic PKT_TYPE_DATA = 1'b0;
    localparam logic PKT_TYPE_CTL  = 1'b1;
    localparam int   DATA_BYTES    = 4;

    // Error flag positions in the low copy; the high copy sits ERR_DUP_OFS above.
    localparam int ERR_OP      = 0;
    localparam int ERR_CRC     = 1;
    localparam int ERR_DATA    = 2;
    localparam int ERR_DUP_OFS = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CTL  = 2'd2
    } rsp_state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  flags;
        logic [5:0]  err;
        logic        is_err;
        logic        chk_ok;
    } rsp_t;

    // x^3+x+1, init 0, message shifted in MSB first.
    function automatic logic [2:0] crc3_calc(input logic [36:0] msg);
        logic [2:0] crc;
        logic       fb;
        crc = 3'b000;
        for (int i = 36; i >= 0; i--) begin
            fb  = crc[2] ^ msg[i];
            crc = {crc[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
        end
        return crc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_rsp_byte_rx.sv
`default_nettype none
// ============================================================================
// Module      : alu_rsp_byte_rx
// Description : 11-bit serial packet receiver; flags packet end on the stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_rsp_byte_rx
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sout,
    output logic       pkt_valid,
    output logic       pkt_type,
    output logic [7:0] pkt_byte,
    output logic       pkt_stop_err,
    output logic       pkt_gap
);

    localparam logic [3:0] STOP_IDX = 4'(PKT_BITS - 2);

    logic       busy_q;
    logic       wait_high_q;
    logic [3:0] bit_cnt_q;
    logic [8:0] shift_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q      <= 1'b0;
            wait_high_q <= 1'b0;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 9'd0;
        end else if (busy_q) begin
            if (bit_cnt_q == STOP_IDX) begin
                busy_q      <= 1'b0;
                bit_cnt_q   <= 4'd0;
                // A low stop bit cannot be trusted as the next start bit.
                wait_high_q <= ~sout;
            end else begin
                shift_q   <= {shift_q[7:0], sout};
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end
        end else if (wait_high_q) begin
            if (sout) begin
                wait_high_q <= 1'b0;
            end
        end else if (!sout) begin
            busy_q <= 1'b1;
        end
    end

    // Packet fields are presented combinationally while the stop bit is on the line.
    assign pkt_valid    = busy_q && (bit_cnt_q == STOP_IDX);
    assign pkt_type     = shift_q[8];
    assign pkt_byte     = shift_q[7:0];
    assign pkt_stop_err = ~sout;
    assign pkt_gap      = !busy_q && (wait_high_q || sout);

endmodule
`default_nettype wire

// File: rtl/alu_rsp_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : alu_rsp_deserializer
// Description : Decodes ALU response frames (data/error) into single-cycle results.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_rsp_deserializer
    import alu_pkg::*;
#(
    parameter int TIMEOUT = 64
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sout,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_flags,
    output logic [5:0]  rsp_err,
    output logic        rsp_is_err,
    output logic        rsp_chk_ok,
    output logic        frame_err
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_SAT  = {IDLE_W{1'b1}};
    localparam logic [1:0]        LAST_BYTE = 2'(DATA_BYTES - 1);

    logic       w_pkt_valid;
    logic       w_pkt_type;
    logic [7:0] w_pkt_byte;
    logic       w_pkt_stop_err;
    logic       w_pkt_gap;

    alu_rsp_byte_rx u_byte_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .sout         (sout),
        .pkt_valid    (w_pkt_valid),
        .pkt_type     (w_pkt_type),
        .pkt_byte     (w_pkt_byte),
        .pkt_stop_err (w_pkt_stop_err),
        .pkt_gap      (w_pkt_gap)
    );

    rsp_state_t        state_q;
    logic [1:0]        byte_idx_q;
    logic [31:0]       data_q;
    logic [IDLE_W-1:0] idle_cnt_q;
    rsp_t              rsp_q;
    logic              rsp_valid_q;
    logic              frame_err_q;

    logic       w_is_ctl;
    logic       w_err_frame;
    logic [3:0] w_flags;
    logic       w_crc_ok;
    logic [5:0] w_err;
    logic       w_par_ok;
    logic       w_dup_ok;

    assign w_is_ctl    = (w_pkt_type == PKT_TYPE_CTL);
    assign w_err_frame = w_pkt_byte[7];
    assign w_flags     = w_pkt_byte[6:3];
    assign w_crc_ok    = (crc3_calc({data_q, 1'b0, w_flags}) == w_pkt_byte[2:0]);
    assign w_err       = w_pkt_byte[6:1];
    assign w_par_ok    = ~^w_pkt_byte;
    assign w_dup_ok    = (w_err[ERR_DATA+ERR_DUP_OFS:ERR_OP+ERR_DUP_OFS] == w_err[ERR_DATA:ERR_OP]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            byte_idx_q  <= 2'd0;
            data_q      <= 32'd0;
            idle_cnt_q  <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            frame_err_q <= 1'b0;

            // Inter-packet gap supervision only applies inside a response.
            if (state_q == ST_IDLE || !w_pkt_gap) begin
                idle_cnt_q <= '0;
            end else if (idle_cnt_q == IDLE_LAST) begin
                idle_cnt_q  <= '0;
                frame_err_q <= 1'b1;
                state_q     <= ST_IDLE;
            end else if (idle_cnt_q != IDLE_SAT) begin
                idle_cnt_q <= idle_cnt_q + 1'b1;
            end

            if (w_pkt_valid) begin
                if (w_pkt_stop_err) begin
                    frame_err_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (w_is_ctl) begin
                                if (w_err_frame) begin
                                    rsp_valid_q   <= 1'b1;
                                    rsp_q.data    <= 32'd0;
                                    rsp_q.flags   <= 4'd0;
                                    rsp_q.err     <= w_err;
                                    rsp_q.is_err  <= 1'b1;
                                    rsp_q.chk_ok  <= w_par_ok && w_dup_ok;
                                end else begin
                                    frame_err_q <= 1'b1;
                                end
                            end else begin
                                data_q     <= {data_q[23:0], w_pkt_byte};
                                byte_idx_q <= 2'd1;
                                state_q    <= ST_DATA;
                            end
                        end
                        ST_DATA: begin
                            if (w_is_ctl) begin
                                frame_err_q <= 1'b1;
                                state_q     <= ST_IDLE;
                            end else begin
                                data_q <= {data_q[23:0], w_pkt_byte};
                                if (byte_idx_q == LAST_BYTE) begin
                                    state_q <= ST_CTL;
                                end else begin
                                    byte_idx_q <= byte_idx_q + 2'd1;
                                end
                            end
                        end
                        ST_CTL: begin
                            if (w_is_ctl && !w_err_frame) begin
                                rsp_valid_q  <= 1'b1;
                                rsp_q.data   <= data_q;
                                rsp_q.flags  <= w_flags;
                                rsp_q.err    <= 6'd0;
                                rsp_q.is_err <= 1'b0;
                                rsp_q.chk_ok <= w_crc_ok;
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                            state_q <= ST_IDLE;
                        end
                        default: begin
                            state_q <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_q.data;
    assign rsp_flags  = rsp_q.flags;
    assign rsp_err    = rsp_q.err;
    assign rsp_is_err = rsp_q.is_err;
    assign rsp_chk_ok = rsp_q.chk_ok;
    assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_rsp_deserializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_alu_rsp_deserializer
// Description : Self-checking bench: table vectors, corner sequences, random frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_rsp_deserializer;

    localparam int TIMEOUT = 64;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        sout  = 1'b1;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_flags;
    logic [5:0]  rsp_err;
    logic        rsp_is_err;
    logic        rsp_chk_ok;
    logic        frame_err;

    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int last_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_rsp_deserializer #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sout       (sout),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_flags  (rsp_flags),
        .rsp_err    (rsp_err),
        .rsp_is_err (rsp_is_err),
        .rsp_chk_ok (rsp_chk_ok),
        .frame_err  (frame_err)
    );

    typedef struct {
        bit          is_fe;
        logic [31:0] data;
        logic [3:0]  flags;
        logic [5:0]  err;
        bit          is_err;
        bit          chk_ok;
        int          at;
    } exp_t;

    typedef struct {
        bit          is_err;
        logic [31:0] c;
        logic [3:0]  f;
        logic [2:0]  crc_xor;
        logic [5:0]  er;
        bit          par_flip;
        int          gap;
        logic [31:0] x_data;
        logic [3:0]  x_flags;
        logic [5:0]  x_err;
        bit          x_is_err;
        bit          x_chk;
    } vec_t;

    exp_t expq[$];
    exp_t last_rsp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Remainder of (message * x^3) divided by x^3+x+1, by long division.
    function automatic logic [2:0] ref_crc(input logic [31:0] c, input logic [3:0] f);
        logic [39:0] r;
        r = {c, 1'b0, f, 3'b000};
        for (int i = 39; i >= 3; i--) begin
            if (r[i]) r = r ^ (40'hB << (i - 3));
        end
        return r[2:0];
    endfunction

    function automatic logic [7:0] ref_err_byte(input logic [5:0] er, input bit par_flip);
        logic par;
        par = ($countones({1'b1, er}) % 2) == 1;
        return {1'b1, er, par ^ par_flip};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid || frame_err) begin
            check("strobe_exclusive", 32'(rsp_valid & frame_err), 32'd0);
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got valid=%0b frame_err=%0b at cycle %0d, required none",
                         rsp_valid, frame_err, cyc);
            end else begin
                e = expq.pop_front();
                check("strobe_kind_fe", 32'(frame_err), 32'(e.is_fe));
                check("strobe_cycle", 32'(cyc), 32'(e.at));
                if (!e.is_fe) begin
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_flags", 32'(rsp_flags), 32'(e.flags));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    check("rsp_is_err", 32'(rsp_is_err), 32'(e.is_err));
                    check("rsp_chk_ok", 32'(rsp_chk_ok), 32'(e.chk_ok));
                    last_rsp = e;
                end
            end
        end
    end

    task automatic drive_bit(input logic b);
        @(negedge clk);
        sout     = b;
        last_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) drive_bit(1'b1);
    endtask

    task automatic send_pkt(input logic typ, input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        drive_bit(typ);
        for (int i = 7; i >= 0; i--) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic send_data(input logic [31:0] c, input logic [3:0] f, input logic [2:0] crc_xor, input int gap);
        for (int k = 3; k >= 0; k--) begin
            send_pkt(1'b0, c[8*k +: 8], 1'b1);
            idle(gap);
        end
        send_pkt(1'b1, {1'b0, f, ref_crc(c, f) ^ crc_xor}, 1'b1);
    endtask

    task automatic expect_rsp(input logic [31:0] d, input logic [3:0] f, input logic [5:0] er,
                              input bit ie, input bit ok);
        exp_t e;
        e.is_fe = 1'b0; e.data = d; e.flags = f; e.err = er;
        e.is_err = ie; e.chk_ok = ok; e.at = last_cyc + 1;
        expq.push_back(e);
    endtask

    task automatic expect_fe();
        exp_t e;
        e.is_fe = 1'b1; e.data = '0; e.flags = '0; e.err = '0;
        e.is_err = 1'b0; e.chk_ok = 1'b0; e.at = last_cyc + 1;
        expq.push_back(e);
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] d, input logic [3:0] f,
                                 input logic [5:0] er, input bit ie, input bit ok);
        check({tag, "_data"}, rsp_data, d);
        check({tag, "_flags"}, 32'(rsp_flags), 32'(f));
        check({tag, "_err"}, 32'(rsp_err), 32'(er));
        check({tag, "_is_err"}, 32'(rsp_is_err), 32'(ie));
        check({tag, "_chk_ok"}, 32'(rsp_chk_ok), 32'(ok));
    endtask

    task automatic clear_last();
        last_rsp.data = '0; last_rsp.flags = '0; last_rsp.err = '0;
        last_rsp.is_err = 1'b0; last_rsp.chk_ok = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vt[8];
        logic [31:0] c;
        logic [3:0]  f;
        logic [5:0]  er;
        logic [2:0]  cx;
        bit          pf;
        int          gap;

        vt[0] = '{0, 32'h12345678, 4'h0, 3'b000, 6'h00, 0, 0,         32'h12345678, 4'h0, 6'h00, 0, 1};
        vt[1] = '{0, 32'h12345678, 4'h0, 3'b001, 6'h00, 0, 0,         32'h12345678, 4'h0, 6'h00, 0, 0};
        vt[2] = '{1, 32'h0,        4'h0, 3'b000, 6'b001001, 0, 0,     32'h0,        4'h0, 6'b001001, 1, 1};
        vt[3] = '{1, 32'h0,        4'h0, 3'b000, 6'b001010, 0, 0,     32'h0,        4'h0, 6'b001010, 1, 0};
        vt[4] = '{1, 32'h0,        4'h0, 3'b000, 6'b010010, 1, 0,     32'h0,        4'h0, 6'b010010, 1, 0};
        vt[5] = '{0, 32'hFFFFFFFF, 4'hF, 3'b000, 6'h00, 0, 0,         32'hFFFFFFFF, 4'hF, 6'h00, 0, 1};
        vt[6] = '{0, 32'h00000000, 4'h2, 3'b000, 6'h00, 0, TIMEOUT-1, 32'h00000000, 4'h2, 6'h00, 0, 1};
        vt[7] = '{1, 32'h0,        4'h0, 3'b000, 6'b111111, 0, 0,     32'h0,        4'h0, 6'b111111, 1, 1};

        clear_last();
        repeat (3) @(negedge clk);
        check("reset_valid", 32'(rsp_valid), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check_outputs("reset", 32'd0, 4'd0, 6'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle(3);

        foreach (vt[i]) begin
            if (vt[i].is_err)
                send_pkt(1'b1, ref_err_byte(vt[i].er, vt[i].par_flip), 1'b1);
            else
                send_data(vt[i].c, vt[i].f, vt[i].crc_xor, vt[i].gap);
            expect_rsp(vt[i].x_data, vt[i].x_flags, vt[i].x_err, vt[i].x_is_err, vt[i].x_chk);
            idle(2);
        end

        // Stop bit low in byte 2, then a clean response.
        send_pkt(1'b0, 8'hA1, 1'b1);
        send_pkt(1'b0, 8'hB2, 1'b1);
        send_pkt(1'b0, 8'hC3, 1'b0);
        expect_fe();
        idle(3);
        check_outputs("hold_stop", last_rsp.data, last_rsp.flags, last_rsp.err, last_rsp.is_err, last_rsp.chk_ok);
        send_data(32'hDEADBEEF, 4'h5, 3'b000, 0);
        expect_rsp(32'hDEADBEEF, 4'h5, 6'h00, 1'b0, 1'b1);
        idle(2);

        // Timeout after byte 1; late bytes must not complete a response.
        send_pkt(1'b0, 8'h11, 1'b1);
        send_pkt(1'b0, 8'h22, 1'b1);
        idle(TIMEOUT);
        expect_fe();
        send_pkt(1'b0, 8'h33, 1'b1);
        send_pkt(1'b0, 8'h44, 1'b1);
        send_pkt(1'b1, {1'b0, 4'h0, ref_crc(32'h11223344, 4'h0)}, 1'b1);
        expect_fe();
        idle(3);
        check_outputs("hold_timeout", last_rsp.data, last_rsp.flags, last_rsp.err, last_rsp.is_err, last_rsp.chk_ok);

        // Malformed sequencing: data-type ctl in IDLE, extra data byte, error ctl in CTL.
        send_pkt(1'b1, 8'h05, 1'b1);
        expect_fe();
        idle(1);
        for (int k = 0; k < 5; k++) send_pkt(1'b0, 8'(k), 1'b1);
        expect_fe();
        idle(1);
        for (int k = 0; k < 4; k++) send_pkt(1'b0, 8'(k), 1'b1);
        send_pkt(1'b1, ref_err_byte(6'b001001, 1'b0), 1'b1);
        expect_fe();
        idle(2);

        // Reset in the middle of the ctl packet.
        for (int k = 3; k >= 0; k--) send_pkt(1'b0, 8'(32'hCAFEF00D >> (8*k)), 1'b1);
        begin
            logic [7:0] cb;
            cb = {1'b0, 4'hA, ref_crc(32'hCAFEF00D, 4'hA)};
            drive_bit(1'b0);
            drive_bit(1'b1);
            for (int i = 7; i >= 4; i--) drive_bit(cb[i]);
            rst_n = 1'b0;
            for (int i = 3; i >= 0; i--) drive_bit(cb[i]);
            drive_bit(1'b1);
        end
        idle(2);
        check_outputs("reset_mid", 32'd0, 4'd0, 6'd0, 1'b0, 1'b0);
        clear_last();
        rst_n = 1'b1;
        idle(2);
        send_data(32'h0BADF00D, 4'h9, 3'b000, 0);
        expect_rsp(32'h0BADF00D, 4'h9, 6'h00, 1'b0, 1'b1);
        send_pkt(1'b1, ref_err_byte(6'b100100, 1'b0), 1'b1);
        expect_rsp(32'd0, 4'd0, 6'b100100, 1'b1, 1'b1);
        send_data(32'h87654321, 4'hC, 3'b100, 0);
        expect_rsp(32'h87654321, 4'hC, 6'h00, 1'b0, 1'b0);
        idle(2);

        // Randomized well-formed responses against the rule-based model.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                er = 6'($urandom);
                if ($urandom_range(0, 1) == 1) er[5:3] = er[2:0];
                pf = ($urandom_range(0, 3) == 0);
                send_pkt(1'b1, ref_err_byte(er, pf), 1'b1);
                expect_rsp(32'd0, 4'd0, er, 1'b1, !pf && (er[5:3] == er[2:0]));
            end else begin
                c   = $urandom;
                f   = 4'($urandom);
                cx  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
                gap = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, TIMEOUT - 1))
                                                  : int'($urandom_range(0, 2));
                send_data(c, f, cx, gap);
                expect_rsp(c, f, 6'd0, 1'b0, cx == 3'd0);
            end
            idle(int'($urandom_range(0, 3)));
        end

        idle(5);
        check("missing_strobes", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
